cic_decimator: RTL and testbench
================================

# cic_decimator

Multi-stage CIC decimator on the ADC receive path of the MAX1000/FX2LP SDR. It sits between the ADC sample source and the FX2LP stream packer, and reduces the sample rate by a runtime ratio. Rate, output scaling and enable come from a 32-bit configuration word driven by a PIO export of the Qsys core, which the host writes over the SPI-to-Avalon bridge. Any configuration change flushes the filter so that no mixed-rate samples reach the host.

## Interface
- `IN_W`, default 12: signed input sample width.
- `OUT_W`, default 16: signed output sample width.
- `STAGES`, default 3: number of integrator stages and number of comb stages (N).
- `RATE_MAX`, default 256: maximum decimation ratio R.
- `clk_clk` input, 1 bit: single clock; all logic is on its rising edge.
- `reset_reset_n` input, 1 bit: asynchronous assert, active-low reset.
- `cfg_word` input, 32 bits: configuration word, driven by the PIO export.
  - [7:0] is R-1; encodings 0 and 1 both mean R=2.
  - [12:8] is the output right-shift.
  - [31] is enable.
- `in_valid` input, 1 bit: qualifies `in_data`. Any duty cycle is allowed, including back-to-back.
- `in_data` input, `IN_W` bits: signed two's-complement sample.
- `out_valid` output, 1 bit: single-cycle strobe, one per decimated sample.
- `out_data` output, `OUT_W` bits: signed, scaled and saturated result.

## Operation
- ACC_W = IN_W + STAGES·log2(RATE_MAX), which is 36 with the defaults. All integrator and comb arithmetic is ACC_W-bit modular; wrap-around is intended and is never saturated internally. `in_data` is sign-extended to ACC_W.
- `cfg_word` is registered into `cfg_q` every cycle.
- Flush:
  - Trigger: `cfg_word` differs from `cfg_q` in bits [31] or [12:0].
  - Timing: the flush takes effect in the next cycle.
  - Cleared: integrators, comb delays, the decimation counter and in-flight valids.
  - Re-armed: the warm-up counter is reloaded to STAGES.
  - `in_valid` is ignored during the flush cycle. Changes to bits [30:13] are ignored.
- Enable: while `cfg_q[31]`=0 the block holds its flushed state and `out_valid` stays 0.
- Integrators (Hogenauer form), on each accepted sample:
  - I1 ← I1 + x.
  - Ik ← Ik + I(k-1), using the registered value of the previous stage.
- Decimation counter:
  - Counts accepted samples from 0 to R-1.
  - On the sample where the count equals R-1 it wraps to 0 and raises the decimation strobe.
- Comb pipeline: one register stage per comb, with Ck = C(k-1) − Zk and Zk ← C(k-1). Each stage carries a valid bit. Combs advance only on a valid.
- Output stage:
  - Compute y = C_N >>> shift (arithmetic shift).
  - Saturate y to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
  - Register the result.
- Warm-up: the first STAGES decimated results after reset or a flush are computed but suppressed (`out_valid`=0). The warm-up counter decrements on each suppressed result.
- Reset values: `out_valid`=0, `out_data`=0, all accumulators 0, counter 0, warm-up counter STAGES, `cfg_q`=0 (disabled).

## Timing
- Latency: an accepted sample at edge t that completes a decimation period gives `out_valid` at edge t+STAGES+2.
  - 1 cycle to capture I_N.
  - STAGES cycles of comb.
  - 1 cycle for scaling and saturation.
- Throughput:
  - One output per R accepted inputs.
  - `out_valid` is never high on two consecutive cycles, because R≥2.
  - There is no backpressure; the consumer must accept every strobe.
- A `cfg_word` change while the comb pipeline is in flight drops that result; `out_valid` stays 0.
- A config change on the same edge as an accepted sample: the sample is consumed before the flush, and its effect is then cleared.
- An `reset_reset_n` assertion mid-pipeline forces all outputs to their reset values immediately, with no strobe generated.

## Structure
- `cic_pkg` holds:
  - the ACC_W calculation function;
  - the `cfg_word` field bit positions (RATE_LSB/MSB, SHIFT_LSB/MSB, EN_BIT);
  - a `sat_shift` function.
- Sub-module `cic_comb_stage`: one registered comb with a valid flag, instantiated STAGES times in a generate loop. The integrators stay inline.

## Test plan
- Constant input, R=4, N=3, shift 0:
  - Stimulus: `cfg_word`=0x8000_0003, `in_data`=100 on every cycle.
  - Required: `out_valid` on every 4th cycle; from the 5th output on, `out_data`=6400.
- Full-scale input, R=256, shift 0:
  - Stimulus: `cfg_word`=0x8000_00FF, `in_data`=2047.
  - Required: settled outputs are 32767 (saturated).
  - With shift 24 (0x8000_18FF), settled outputs are 2047.
- Negative full scale:
  - Stimulus: `in_data`=−2048, R=256, shift 24.
  - Required: settled outputs are −2048, with no wrap glitch over 10^5 inputs.
- Mid-run config change:
  - Stimulus: switch R from 4 to 8 one cycle after a decimation strobe.
  - Required: the in-flight result is dropped, the next 3 results are suppressed, and the spacing is then 8 inputs.
- Sparse input:
  - Stimulus: `in_valid` at 1-in-3 duty, R=2.
  - Required: one output per 2 accepted samples; latency is STAGES+2 cycles from the completing sample.
- Reset:
  - Stimulus: assert `reset_reset_n`=0 asynchronously mid-pipeline.
  - Required: `out_valid`/`out_data` go to 0 immediately, and no output appears until a write with enable=1.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared constants and helpers for the CIC decimator: configuration word
// layout, accumulator width rule and the output scale/saturate function.
package cic_pkg;

  localparam int RATE_LSB  = 0;
  localparam int RATE_MSB  = 7;
  localparam int SHIFT_LSB = 8;
  localparam int SHIFT_MSB = 12;
  localparam int EN_BIT    = 31;

  // Bit growth of an N-stage CIC at ratio R is N*log2(R) on top of the input.
  function automatic int acc_width(input int in_w, input int stages, input int rate_max);
    return in_w + stages * $clog2(rate_max);
  endfunction

  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] v,
                                                   input logic [4:0]         sh,
                                                   input int                 out_w);
    logic signed [63:0] y;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    y  = v >>> sh;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (y > hi) begin
      return hi;
    end else if (y < lo) begin
      return lo;
    end
    return y;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One registered comb section (C = in - Z, Z <= in) with a travelling valid bit.
module cic_comb_stage
#(
  parameter int W = 36
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                in_valid,
  input  logic signed [W-1:0] in_data,
  output logic                out_valid,
  output logic signed [W-1:0] out_data
);

  logic signed [W-1:0] z_q, z_d;
  logic signed [W-1:0] c_q, c_d;
  logic                v_q, v_d;

  always_comb begin
    z_d = z_q;
    c_d = c_q;
    v_d = in_valid;
    if (in_valid) begin
      c_d = in_data - z_q;
      z_d = in_data;
    end
    if (clear) begin
      z_d = '0;
      c_d = '0;
      v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q <= '0;
      c_q <= '0;
      v_q <= 1'b0;
    end else begin
      z_q <= z_d;
      c_q <= c_d;
      v_q <= v_d;
    end
  end

  assign out_valid = v_q;
  assign out_data  = c_q;

endmodule

// File: rtl/cic_decimator.sv
// N-stage CIC decimator with runtime ratio/shift/enable; any relevant config
// change flushes the whole filter and re-arms the warm-up suppression.
module cic_decimator
  import cic_pkg::*;
#(
  parameter int IN_W     = 12,
  parameter int OUT_W    = 16,
  parameter int STAGES   = 3,
  parameter int RATE_MAX = 256
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  input  logic [31:0]             cfg_word,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_data
);

  localparam int ACC_W  = acc_width(IN_W, STAGES, RATE_MAX);
  localparam int CNT_W  = RATE_MSB - RATE_LSB + 1;
  localparam int WARM_W = $clog2(STAGES + 1);

  logic [31:0]              cfg_q, cfg_d;
  logic                     flush_q, flush_d;
  logic signed [ACC_W-1:0]  integ_q [STAGES];
  logic signed [ACC_W-1:0]  integ_d [STAGES];
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     strobe_q, strobe_d;
  logic signed [ACC_W-1:0]  cap_q, cap_d;
  logic                     cap_v_q, cap_v_d;
  logic [WARM_W-1:0]        warm_q, warm_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0]  out_data_q, out_data_d;

  logic signed [ACC_W-1:0]  x_ext;
  logic [CNT_W-1:0]         rate_m1;
  logic [4:0]               shift_amt;
  logic                     clear;
  logic                     accept;
  logic signed [63:0]       sat_full;
  logic signed [ACC_W-1:0]  comb_data  [STAGES+1];
  logic                     comb_valid [STAGES+1];
  logic                     unused_bits;

  assign x_ext     = ACC_W'(in_data);
  assign rate_m1   = (cfg_q[RATE_MSB:RATE_LSB] < CNT_W'(2)) ? CNT_W'(1) : cfg_q[RATE_MSB:RATE_LSB];
  assign shift_amt = cfg_q[SHIFT_MSB:SHIFT_LSB];
  // Disabled is treated exactly like a flush that never ends.
  assign clear     = flush_q | ~cfg_q[EN_BIT];
  assign accept    = in_valid & ~clear;
  assign sat_full  = sat_shift(64'(comb_data[STAGES]), shift_amt, OUT_W);
  assign unused_bits = ^{cfg_q[EN_BIT-1:SHIFT_MSB+1], sat_full[63:OUT_W]};

  always_comb begin
    cfg_d   = cfg_word;
    flush_d = (cfg_word[EN_BIT] != cfg_q[EN_BIT]) ||
              (cfg_word[SHIFT_MSB:RATE_LSB] != cfg_q[SHIFT_MSB:RATE_LSB]);
  end

  always_comb begin
    integ_d     = integ_q;
    cnt_d       = cnt_q;
    strobe_d    = 1'b0;
    cap_d       = strobe_q ? integ_q[STAGES-1] : cap_q;
    cap_v_d     = strobe_q;
    warm_d      = warm_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;

    // Hogenauer chain: each stage adds the previous stage's registered value.
    if (accept) begin
      integ_d[0] = integ_q[0] + x_ext;
      for (int k = 1; k < STAGES; k++) begin
        integ_d[k] = integ_q[k] + integ_q[k-1];
      end
      if (cnt_q == rate_m1) begin
        cnt_d    = '0;
        strobe_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (comb_valid[STAGES]) begin
      if (warm_q != '0) begin
        warm_d = warm_q - 1'b1;
      end else begin
        out_valid_d = 1'b1;
        out_data_d  = sat_full[OUT_W-1:0];
      end
    end

    if (clear) begin
      for (int k = 0; k < STAGES; k++) begin
        integ_d[k] = '0;
      end
      cnt_d       = '0;
      strobe_d    = 1'b0;
      cap_d       = '0;
      cap_v_d     = 1'b0;
      warm_d      = WARM_W'(STAGES);
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cfg_q       <= '0;
      flush_q     <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        integ_q[k] <= '0;
      end
      cnt_q       <= '0;
      strobe_q    <= 1'b0;
      cap_q       <= '0;
      cap_v_q     <= 1'b0;
      warm_q      <= WARM_W'(STAGES);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      cfg_q       <= cfg_d;
      flush_q     <= flush_d;
      integ_q     <= integ_d;
      cnt_q       <= cnt_d;
      strobe_q    <= strobe_d;
      cap_q       <= cap_d;
      cap_v_q     <= cap_v_d;
      warm_q      <= warm_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign comb_data[0]  = cap_q;
  assign comb_valid[0] = cap_v_q;

  for (genvar g = 0; g < STAGES; g++) begin : g_comb
    cic_comb_stage #(.W(ACC_W)) u_comb (
      .clk       (clk_clk),
      .rst_n     (reset_reset_n),
      .clear     (clear),
      .in_valid  (comb_valid[g]),
      .in_data   (comb_data[g]),
      .out_valid (comb_valid[g+1]),
      .out_data  (comb_data[g+1])
    );
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_cic_decimator.sv
// Bench for cic_decimator: binomial-form reference model feeding a timed
// scoreboard, a table of steady-state vectors and a few hand-built sequences.
module tb_cic_decimator;

  localparam int IN_W     = 12;
  localparam int OUT_W    = 16;
  localparam int STAGES   = 3;
  localparam int RATE_MAX = 256;
  localparam int ACC_W    = 36;
  localparam int LAT      = STAGES + 2;

  logic                    clk_clk = 1'b0;
  logic                    reset_reset_n;
  logic [31:0]             cfg_word;
  logic                    in_valid;
  logic signed [IN_W-1:0]  in_data;
  logic                    out_valid;
  logic signed [OUT_W-1:0] out_data;

  cic_decimator #(
    .IN_W(IN_W), .OUT_W(OUT_W), .STAGES(STAGES), .RATE_MAX(RATE_MAX)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .cfg_word      (cfg_word),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_data      (out_data)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct {
    int                      due;
    logic signed [OUT_W-1:0] data;
  } exp_t;

  typedef struct {
    logic [31:0] cfg;
    int          data;
    int          cycles;
    int          settle_idx;
    int          exp_val;
  } vec_t;

  exp_t                    sb_q[$];
  int                      seen_cyc[$];
  logic signed [OUT_W-1:0] seen_dat[$];
  int total = 0;
  int bad   = 0;
  int cycle = 0;

  logic [31:0]             m_cfg;
  bit                      m_flush;
  logic signed [ACC_W-1:0] m_i [STAGES];
  logic signed [ACC_W-1:0] m_h [4];
  int                      m_cnt;
  int                      m_warm;

  function automatic logic signed [OUT_W-1:0] ref_sat(input logic signed [ACC_W-1:0] v,
                                                      input logic [4:0] sh);
    logic signed [ACC_W-1:0] s;
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    s  = v >>> sh;
    hi = ACC_W'(32767);
    lo = -ACC_W'(32768);
    if (s > hi) return 16'sh7fff;
    if (s < lo) return 16'sh8000;
    return s[OUT_W-1:0];
  endfunction

  function void model_clear();
    for (int k = 0; k < STAGES; k++) m_i[k] = '0;
    for (int k = 0; k < 4; k++) m_h[k] = '0;
    m_cnt  = 0;
    m_warm = STAGES;
  endfunction

  // Predicts what the coming clock edge does; the comb is evaluated in its
  // expanded binomial form h0 - 3h1 + 3h2 - h3 over the decimated I_N history.
  task automatic model_step();
    int                      e;
    bit                      clr;
    int                      rm1;
    logic signed [ACC_W-1:0] old_i [STAGES];
    logic signed [ACC_W-1:0] y;
    exp_t                    ex;
    e = cycle + 1;
    if (!reset_reset_n) begin
      m_cfg   = '0;
      m_flush = 1'b0;
      model_clear();
      sb_q.delete();
      return;
    end
    clr = m_flush || !m_cfg[31];
    if (clr) begin
      model_clear();
      while (sb_q.size() > 0 && sb_q[$].due >= e) void'(sb_q.pop_back());
    end else if (in_valid) begin
      old_i = m_i;
      m_i[0] = old_i[0] + ACC_W'(in_data);
      for (int k = 1; k < STAGES; k++) m_i[k] = old_i[k] + old_i[k-1];
      rm1 = (m_cfg[7:0] < 8'd2) ? 1 : int'(m_cfg[7:0]);
      if (m_cnt == rm1) begin
        m_cnt  = 0;
        m_h[3] = m_h[2];
        m_h[2] = m_h[1];
        m_h[1] = m_h[0];
        m_h[0] = m_i[STAGES-1];
        y = m_h[0] - 3 * m_h[1] + 3 * m_h[2] - m_h[3];
        if (m_warm > 0) begin
          m_warm--;
        end else begin
          ex.due  = e + LAT;
          ex.data = ref_sat(y, m_cfg[12:8]);
          sb_q.push_back(ex);
        end
      end else begin
        m_cnt++;
      end
    end
    m_flush = (cfg_word[31] != m_cfg[31]) || (cfg_word[12:0] != m_cfg[12:0]);
    m_cfg   = cfg_word;
  endtask

  task automatic checkOutput();
    exp_t ex;
    if (sb_q.size() > 0 && sb_q[0].due == cycle) begin
      ex = sb_q.pop_front();
      total++;
      if (out_valid !== 1'b1 || out_data !== ex.data) begin
        bad++;
        $display("[TB] FAIL sample@%0d: valid=%0b data=%0d, required valid=1 data=%0d",
                 cycle, out_valid, out_data, ex.data);
      end
    end else if (out_valid !== 1'b0) begin
      total++;
      bad++;
      $display("[TB] FAIL unexpected strobe@%0d: valid=%0b data=%0d, required valid=0",
               cycle, out_valid, out_data);
    end
    if (out_valid === 1'b1) begin
      seen_cyc.push_back(cycle);
      seen_dat.push_back(out_data);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_clk);
    #1;
    cycle++;
    checkOutput();
  endtask

  task automatic applyStimulus(input logic [31:0] cfg, input int data, input logic v);
    cfg_word = cfg;
    in_data  = IN_W'(data);
    in_valid = v;
  endtask

  task automatic check_eq(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic clear_seen();
    seen_cyc.delete();
    seen_dat.delete();
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   c;
    bit   found;

    vecs[0] = '{32'h8000_0003,   100,   80, 5,   6400};
    vecs[1] = '{32'h8000_00FF,  2047, 2048, 3,  32767};
    vecs[2] = '{32'h8000_18FF,  2047, 2048, 3,   2047};
    vecs[3] = '{32'h8000_18FF, -2048, 5120, 5,  -2048};
    vecs[4] = '{32'h8000_00FF, -2048, 2048, 3, -32768};
    vecs[5] = '{32'h8000_0403,   100,   80, 5,    400};
    vecs[6] = '{32'h8000_0000,    50,   40, 3,    400};
    vecs[7] = '{32'h8000_0001,  -100,   40, 3,   -800};

    reset_reset_n = 1'b0;
    applyStimulus(32'h0, 0, 1'b0);
    repeat (3) tick();
    check_eq("reset out_valid", int'(out_valid), 0);
    check_eq("reset out_data", int'(out_data), 0);
    reset_reset_n = 1'b1;

    applyStimulus(32'h0, 300, 1'b1);
    clear_seen();
    repeat (20) tick();
    check_eq("disabled no output", seen_cyc.size(), 0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].cfg, vecs[i].data, 1'b1);
      repeat (2) tick();
      clear_seen();
      repeat (vecs[i].cycles) tick();
      check_eq($sformatf("vec%0d settled count", i),
               int'(seen_cyc.size() >= vecs[i].settle_idx), 1);
      for (int j = vecs[i].settle_idx - 1; j < seen_dat.size(); j++) begin
        check_eq($sformatf("vec%0d out%0d", i, j + 1), int'(seen_dat[j]), vecs[i].exp_val);
      end
    end

    // R 4 -> 8 one cycle after a strobe.
    applyStimulus(32'h8000_0003, 37, 1'b1);
    repeat (40) tick();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (out_valid) found = 1'b1;
    end
    check_eq("strobe before switch", int'(found), 1);
    c = cycle;
    applyStimulus(32'h8000_0007, 37, 1'b1);
    clear_seen();
    repeat (70) tick();
    check_eq("switch outputs seen", int'(seen_cyc.size() >= 3), 1);
    if (seen_cyc.size() >= 3) begin
      check_eq("switch first output delay", seen_cyc[0] - c, 39);
      check_eq("switch spacing 1", seen_cyc[1] - seen_cyc[0], 8);
      check_eq("switch spacing 2", seen_cyc[2] - seen_cyc[1], 8);
    end

    // 1-in-3 input duty at R=2 with varying data.
    applyStimulus(32'h8000_0001, 0, 1'b1);
    repeat (2) tick();
    clear_seen();
    for (int k = 0; k < 90; k++) begin
      applyStimulus(32'h8000_0001, ((k * 37) % 4000) - 2000, 1'(k % 3 == 0));
      tick();
    end
    check_eq("sparse outputs seen", int'(seen_cyc.size() >= 8), 1);
    for (int j = 1; j < seen_cyc.size(); j++) begin
      check_eq($sformatf("sparse spacing %0d", j), seen_cyc[j] - seen_cyc[j-1], 6);
    end

    // Asynchronous reset in the middle of a running pipeline.
    applyStimulus(32'h8000_0003, 500, 1'b1);
    repeat (2) tick();
    clear_seen();
    repeat (33) tick();
    check_eq("pre-reset running", int'(seen_dat.size() > 0 && seen_dat[$] == 16'sd32000), 1);
    #2;
    reset_reset_n = 1'b0;
    #1;
    check_eq("async reset out_valid", int'(out_valid), 0);
    check_eq("async reset out_data", int'(out_data), 0);
    applyStimulus(32'h0, 500, 1'b1);
    repeat (2) tick();
    reset_reset_n = 1'b1;
    clear_seen();
    repeat (40) tick();
    check_eq("post-reset silent", seen_cyc.size(), 0);
    applyStimulus(32'h8000_0003, 500, 1'b1);
    repeat (40) tick();
    check_eq("post-enable outputs", int'(seen_cyc.size() > 0), 1);
    if (seen_dat.size() > 0) begin
      check_eq("post-enable value", int'(seen_dat[$]), 32000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
